// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: CPU SRAM-style request port to single-beat AXI3 master.
// Only one transaction is outstanding; data_ok pulses one cycle after the final handshake.
module sram_axi_bridge #(
    parameter logic [3:0] RD_ID = 4'd0,
    parameter logic [3:0] WR_ID = 4'd1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        addr_ok_o,
    output logic        data_ok_o,
    output logic [31:0] rdata_o,
    output logic [3:0]  arid_o,
    output logic [31:0] araddr_o,
    output logic [7:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    output logic [1:0]  arlock_o,
    output logic [3:0]  arcache_o,
    output logic [2:0]  arprot_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [3:0]  rid_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic [3:0]  awid_o,
    output logic [31:0] awaddr_o,
    output logic [7:0]  awlen_o,
    output logic [2:0]  awsize_o,
    output logic [1:0]  awburst_o,
    output logic [1:0]  awlock_o,
    output logic [3:0]  awcache_o,
    output logic [2:0]  awprot_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [3:0]  wid_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic [3:0]  bid_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;
    state_t      state_q, state_d;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d, data_ok_q, data_ok_d;
    logic        aw_set, w_set;
    logic        unused_ok;
    assign unused_ok = ^{rid_i, rresp_i, rlast_i, bid_i, bresp_i};
    assign addr_ok_o = req_i && (state_q == IDLE);
    assign data_ok_o = data_ok_q;
    assign rdata_o   = rdata_q;
    assign arvalid_o = state_q == RD_ADDR;
    assign rready_o  = state_q == RD_DATA;
    assign awvalid_o = (state_q == WR_REQ) && !aw_done_q;
    assign wvalid_o  = (state_q == WR_REQ) && !w_done_q;
    assign bready_o  = state_q == WR_RESP;
    assign aw_set    = aw_done_q || (awvalid_o && awready_i);
    assign w_set     = w_done_q || (wvalid_o && wready_i);
    assign arid_o    = RD_ID;
    assign awid_o    = WR_ID;
    assign wid_o     = WR_ID;
    assign araddr_o  = addr_q;
    assign awaddr_o  = addr_q;
    assign arsize_o  = (size_q == 2'd3) ? 3'd2 : {1'b0, size_q};
    assign awsize_o  = arsize_o;
    assign arlen_o   = 8'd0;
    assign awlen_o   = 8'd0;
    assign arburst_o = 2'b01;
    assign awburst_o = 2'b01;
    assign arlock_o  = 2'b00;
    assign awlock_o  = 2'b00;
    assign arcache_o = 4'd0;
    assign awcache_o = 4'd0;
    assign arprot_o  = 3'd0;
    assign awprot_o  = 3'd0;
    assign wdata_o   = wdata_q;
    assign wlast_o   = 1'b1;
    assign wstrb_o   = (size_q == 2'd0) ? 4'b0001 << addr_q[1:0] :
                       (size_q == 2'd1) ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        data_ok_d = 1'b0;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE:    if (req_i) state_d = wr_i ? WR_REQ : RD_ADDR;
            RD_ADDR: if (arready_i) state_d = RD_DATA;
            RD_DATA: if (rvalid_i) begin
                state_d   = IDLE;
                data_ok_d = 1'b1;
                rdata_d   = wr_q ? rdata_q : rdata_i;
            end
            WR_REQ: begin
                // Address and data handshakes complete independently, in any order.
                aw_done_d = aw_set && !w_set;
                w_done_d  = w_set && !aw_set;
                if (aw_set && w_set) state_d = WR_RESP;
            end
            WR_RESP: if (bvalid_i) begin
                state_d   = IDLE;
                data_ok_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end
    always_ff @(posedge aclk) begin
        if (addr_ok_o) begin
            wr_q    <= wr_i;
            size_q  <= size_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end
endmodule
